guard_insert_mc: RTL and testbench

Parametrised multi-channel guard-interval inserter for the OFDM transmit chain. It sits after the cyclic-prefix stage and before the DAC interface. It passes AXI-Stream symbols through and, after each symbol boundary, stalls the input while emitting a programmable number of guard beats, filled with zeros or a held sample. The first symbol of a frame (preamble) has its own length.

---
 rtl/guard_insert_pkg.sv | 27 ++
 rtl/guard_sym_counter.sv | 64 ++++++
 rtl/guard_insert_mc.sv | 163 ++++++++++++++++
 tb/tb_guard_insert_mc.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guard_insert_pkg.sv
// Shared types and symbol-length helper for the guard-interval inserter.
package guard_insert_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        GUARD = 2'd2
    } state_t;

    typedef enum logic {
        FILL_ZERO   = 1'b0,
        FILL_REPEAT = 1'b1
    } fill_mode_t;

    // Length fields arrive as "minus one" values; operands are widened first so the sum never wraps.
    function automatic logic [63:0] calc_sym_len(input logic        is_pre,
                                                 input logic [63:0] pre_len,
                                                 input logic [63:0] nfft,
                                                 input logic [63:0] cp_len,
                                                 input logic        cp_en);
        if (is_pre) begin
            return pre_len + 64'd1;
        end
        return nfft + 64'd1 + (cp_en ? cp_len + 64'd1 : 64'd0);
    endfunction

endpackage

// File: rtl/guard_sym_counter.sv
// Per-frame symbol position tracker: latches symbol lengths at frame start and
// flags the beat that closes the current symbol.
module guard_sym_counter
    import guard_insert_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int NFFT_W = 14,
    parameter int CP_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              adv,
    input  logic              abort,
    input  logic [CNT_W-1:0]  pre_len,
    input  logic [NFFT_W-1:0] nfft,
    input  logic [CP_W-1:0]   cp_len,
    input  logic              cp_en,
    output logic              boundary
);

    localparam int LEN_W = CNT_W + 1;

    logic [LEN_W-1:0] len_pre_q, len_sym_q, beat_cnt;
    logic [LEN_W-1:0] len_pre_live, len_sym_live, len_now, cnt_now;
    logic             pre_q;

    // The first beat of a frame is judged against the live config, since the latch lands a cycle later.
    always_comb begin
        len_pre_live = LEN_W'(calc_sym_len(1'b1, 64'(pre_len), 64'(nfft), 64'(cp_len), cp_en));
        len_sym_live = LEN_W'(calc_sym_len(1'b0, 64'(pre_len), 64'(nfft), 64'(cp_len), cp_en));
        cnt_now      = start ? '0 : beat_cnt;
        len_now      = start ? len_pre_live : (pre_q ? len_pre_q : len_sym_q);
        boundary     = adv && (cnt_now == len_now - LEN_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_pre_q <= '0;
            len_sym_q <= '0;
            beat_cnt  <= '0;
            pre_q     <= 1'b1;
        end else begin
            if (start) begin
                len_pre_q <= len_pre_live;
                len_sym_q <= len_sym_live;
            end
            if (adv) begin
                if (boundary) begin
                    beat_cnt <= '0;
                    pre_q    <= 1'b0;
                end else begin
                    beat_cnt <= cnt_now + LEN_W'(1);
                    pre_q    <= start ? 1'b1 : pre_q;
                end
            end
            if (abort) begin
                beat_cnt <= '0;
                pre_q    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/guard_insert_mc.sv
// Multi-channel guard-interval inserter: forwards symbols and stalls the input for
// guard beats after each symbol. Build macro GUARD_INSERT_MC_STATS_EN enables o_sym_count/o_err_short.
module guard_insert_mc
    import guard_insert_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NCH    = 1,
    parameter int CNT_W  = 32,
    parameter int NFFT_W = 14,
    parameter int CP_W   = 12
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [NCH*DATA_W-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [NCH*DATA_W-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic [CNT_W-1:0]      i_guard_cycles,
    input  logic [NFFT_W-1:0]     i_nfft,
    input  logic [CP_W-1:0]       i_cp_len,
    input  logic                  i_cp_en,
    input  logic [CNT_W-1:0]      i_pre_len,
    input  logic                  i_fill_mode,
    output logic                  o_busy,
    output logic [15:0]           o_sym_count,
    output logic                  o_err_short,
    output logic [1:0]            o_state
);

    localparam int TW = NCH * DATA_W;

    // Valid/ready: a beat moves on a rising edge where valid and ready are both high;
    // once m_axis_tvalid is raised, data and tlast hold until m_axis_tready accepts them.

    state_t           state, state_nx;
    fill_mode_t       fill_mode_q;
    logic [CNT_W-1:0] guard_q, guard_cnt, guard_eff;
    logic [TW-1:0]    fill_q;
    logic             frame_end_q;
    logic             out_ready, s_fire, start, bnd, early, guard_last;

    assign out_ready     = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = !areset && (state != GUARD) && out_ready;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign start         = s_fire && (state == IDLE);
    assign guard_eff     = (state == IDLE) ? i_guard_cycles : guard_q;
    assign early         = s_fire && s_axis_tlast && !bnd;
    assign guard_last    = (guard_cnt == guard_q - CNT_W'(1));
    assign o_busy        = (state != IDLE);
    assign o_state       = state;

    guard_sym_counter #(
        .CNT_W (CNT_W),
        .NFFT_W(NFFT_W),
        .CP_W  (CP_W)
    ) u_sym (
        .clk     (aclk),
        .rst     (areset),
        .start   (start),
        .adv     (s_fire),
        .abort   (early),
        .pre_len (i_pre_len),
        .nfft    (i_nfft),
        .cp_len  (i_cp_len),
        .cp_en   (i_cp_en),
        .boundary(bnd)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, PASS: begin
                if (s_fire) begin
                    if ((bnd || s_axis_tlast) && (guard_eff != '0)) begin
                        state_nx = GUARD;
                    end else if (s_axis_tlast) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = PASS;
                    end
                end
            end
            GUARD: begin
                if (out_ready && guard_last) begin
                    state_nx = frame_end_q ? IDLE : PASS;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            guard_q       <= '0;
            guard_cnt     <= '0;
            fill_mode_q   <= FILL_ZERO;
            fill_q        <= '0;
            frame_end_q   <= 1'b0;
        end else begin
            if (start) begin
                guard_q     <= i_guard_cycles;
                fill_mode_q <= fill_mode_t'(i_fill_mode);
            end
            if (s_fire) begin
                fill_q        <= s_axis_tdata;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= s_axis_tlast && (guard_eff == '0);
                frame_end_q   <= s_axis_tlast;
                guard_cnt     <= '0;
            end else if ((state == GUARD) && out_ready) begin
                m_axis_tdata  <= (fill_mode_q == FILL_REPEAT) ? fill_q : '0;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= frame_end_q && guard_last;
                guard_cnt     <= guard_cnt + CNT_W'(1);
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

`ifdef GUARD_INSERT_MC_STATS_EN
    logic [15:0] sym_count_q;
    logic        err_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sym_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= early;
            if (start) begin
                sym_count_q <= bnd ? 16'd1 : 16'd0;
            end else if (bnd) begin
                sym_count_q <= sym_count_q + 16'd1;
            end
        end
    end

    assign o_sym_count = sym_count_q;
    assign o_err_short = err_q;
`else
    assign o_sym_count = 16'd0;
    assign o_err_short = 1'b0;
`endif

endmodule

// File: tb/tb_guard_insert_mc.sv
// Bench for guard_insert_mc (NCH=2): table of frame vectors, hand sequences for reset-in-guard,
// and random frames, all checked against a symbol-level model of the output stream.
module tb_guard_insert_mc;

    localparam int DATA_W = 32;
    localparam int NCH    = 2;
    localparam int TW     = NCH * DATA_W;
    localparam int CNT_W  = 32;
    localparam int NFFT_W = 14;
    localparam int CP_W   = 12;
`ifdef GUARD_INSERT_MC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              aclk = 1'b0;
    logic              areset;
    logic [TW-1:0]     s_axis_tdata;
    logic              s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [TW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [CNT_W-1:0]  i_guard_cycles, i_pre_len;
    logic [NFFT_W-1:0] i_nfft;
    logic [CP_W-1:0]   i_cp_len;
    logic              i_cp_en, i_fill_mode;
    logic              o_busy, o_err_short;
    logic [15:0]       o_sym_count;
    logic [1:0]        o_state;

    guard_insert_mc #(
        .DATA_W(DATA_W), .NCH(NCH), .CNT_W(CNT_W), .NFFT_W(NFFT_W), .CP_W(CP_W)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .i_guard_cycles(i_guard_cycles), .i_nfft(i_nfft), .i_cp_len(i_cp_len),
        .i_cp_en(i_cp_en), .i_pre_len(i_pre_len), .i_fill_mode(i_fill_mode),
        .o_busy(o_busy), .o_sym_count(o_sym_count), .o_err_short(o_err_short),
        .o_state(o_state)
    );

    // ---------------- clock ----------------
    always #5 aclk = ~aclk;

    typedef struct {
        int          guard;
        int          nfft;
        int          cp_len;
        bit          cp_en;
        int          pre_len;
        bit          fill;
        int          n;
        int          exp_out;
        int          exp_syms;
        int          exp_err;
        int          stall;
        logic [63:0] last_word;
    } vec_t;

    int            n_pass = 0;
    int            n_total = 0;
    logic [TW:0]   exp_q[$];
    logic [TW-1:0] stim[];
    int            out_beats, err_seen, stall_pct, model_syms, model_errs, model_out;
    bit            mon_en = 1'b0;
    logic [TW-1:0] last_out;

    function automatic void check(string name, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // ---------------- sink back-pressure ----------------
    always @(posedge aclk) begin
        #1;
        m_axis_tready = (int'($urandom_range(0, 99)) >= stall_pct);
    end

    // ---------------- scoreboard / monitor ----------------
    logic          held = 1'b0;
    logic [TW-1:0] held_data;
    logic          held_last;
    logic [TW:0]   exp_beat;

    always @(negedge aclk) begin
        if (areset || !mon_en) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_ctrl", longint'({m_axis_tvalid, m_axis_tlast}), longint'({1'b1, held_last}));
                check("hold_data", longint'(m_axis_tdata), longint'(held_data));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_beats++;
                last_out = m_axis_tdata;
                if (exp_q.size() == 0) begin
                    check("extra_beat", longint'(m_axis_tdata), 0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("out_data", longint'(m_axis_tdata), longint'(exp_beat[TW-1:0]));
                    check("out_last", longint'(m_axis_tlast), longint'(exp_beat[TW]));
                end
            end
            held      = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            held_last = m_axis_tlast;
            if (o_err_short) err_seen++;
        end
    end

    // Reference: a frame is a run of symbols (preamble first); each symbol, full or cut short
    // by tlast, is followed by `guard` fill beats; tlast marks the final beat of the frame.
    function automatic void model_frame(vec_t v);
        int            pos = 0;
        bit            first = 1'b1;
        int            len, take;
        logic [TW-1:0] fill;
        logic [TW:0]   tail;
        model_syms = 0;
        model_errs = 0;
        while (pos < v.n) begin
            len  = first ? v.pre_len + 1 : v.nfft + 1 + (v.cp_en ? v.cp_len + 1 : 0);
            take = (v.n - pos < len) ? v.n - pos : len;
            for (int k = 0; k < take; k++) exp_q.push_back({1'b0, stim[pos + k]});
            fill  = v.fill ? stim[pos + take - 1] : '0;
            pos  += take;
            first = 1'b0;
            if (take == len) model_syms++;
            else model_errs++;
            if (v.guard == 0) begin
                if (pos == v.n) begin
                    tail     = exp_q.pop_back();
                    tail[TW] = 1'b1;
                    exp_q.push_back(tail);
                end
            end else begin
                for (int g = 0; g < v.guard; g++)
                    exp_q.push_back({(pos == v.n) && (g == v.guard - 1), fill});
            end
        end
    endfunction

    // ---------------- driver ----------------
    task automatic run_vec(input string tag, input vec_t v);
        int cyc;
        bit acc;
        int exp_s, exp_e;
        stim = new[v.n];
        foreach (stim[i]) stim[i] = {$urandom, $urandom};
        if (v.last_word != 64'd0) stim[v.n - 1] = v.last_word;
        exp_q.delete();
        out_beats = 0;
        err_seen  = 0;
        stall_pct = v.stall;
        model_frame(v);
        model_out = exp_q.size();

        i_guard_cycles = v.guard;
        i_nfft         = v.nfft[NFFT_W-1:0];
        i_cp_len       = v.cp_len[CP_W-1:0];
        i_cp_en        = v.cp_en;
        i_pre_len      = v.pre_len;
        i_fill_mode    = v.fill;

        for (int i = 0; i < v.n; i++) begin
            if (v.stall > 0 && $urandom_range(0, 99) < 15) begin
                s_axis_tvalid = 1'b0;
                @(posedge aclk); #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = stim[i];
            s_axis_tlast  = (i == v.n - 1);
            cyc = 0;
            do begin
                @(negedge aclk);
                acc = s_axis_tready;
                @(posedge aclk); #1;
                cyc++;
            end while (!acc && cyc < 1000);
            if (!acc) begin
                check({tag, "_accept_timeout"}, 0, 1);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 5000) begin
            @(posedge aclk); #1;
            cyc++;
        end
        repeat (5) @(posedge aclk);
        #1;
        check({tag, "_drained"}, longint'(exp_q.size()), 0);
        check({tag, "_beats_vs_model"}, longint'(out_beats), longint'(model_out));
        if (v.exp_out >= 0) check({tag, "_beats_vs_table"}, longint'(out_beats), longint'(v.exp_out));
        exp_s = (v.exp_syms >= 0) ? v.exp_syms : model_syms;
        exp_e = (v.exp_err >= 0) ? v.exp_err : model_errs;
        check({tag, "_sym_count"}, longint'(o_sym_count), STATS ? longint'(exp_s) : 0);
        check({tag, "_err_pulses"}, longint'(err_seen), STATS ? longint'(exp_e) : 0);
        check({tag, "_idle"}, longint'({o_busy, o_state}), 0);
        if (v.fill && v.last_word != 64'd0 && v.guard > 0)
            check({tag, "_fill_word"}, longint'(last_out), longint'(v.last_word));
    endtask

    // ---------------- test ----------------
    vec_t tbl[10];
    vec_t rv;

    initial begin
        //        guard nfft cp cpen pre  fill n     out   syms err stall last_word
        // case 1 output: 4096+10 + 37+10 + 37+10 = 4200 beats
        tbl[0] = '{10, 31, 4, 1'b1, 4095, 1'b0, 4170, 4200, 3, 0, 0,  64'd0};
        tbl[1] = '{0,  31, 0, 1'b0, 31,   1'b0, 64,   64,   2, 0, 0,  64'd0};
        tbl[2] = '{10, 31, 4, 1'b1, 36,   1'b1, 37,   47,   1, 0, 0,  64'hAAAA0001_BBBB0002};
        tbl[3] = '{10, 31, 4, 1'b1, 4,    1'b0, 26,   46,   1, 1, 0,  64'd0};
        tbl[4] = '{10, 31, 4, 1'b1, 4,    1'b0, 42,   62,   2, 0, 0,  64'd0};
        tbl[5] = '{3,  7,  1, 1'b1, 11,   1'b1, 42,   54,   4, 0, 0,  64'd0};
        tbl[6] = '{3,  7,  1, 1'b1, 11,   1'b1, 42,   54,   4, 0, 30, 64'd0};
        tbl[7] = '{1,  3,  0, 1'b0, 0,    1'b1, 9,    12,   3, 0, 0,  64'd0};
        tbl[8] = '{0,  7,  0, 1'b0, 15,   1'b0, 6,    6,    0, 1, 0,  64'd0};
        tbl[9] = '{2,  3,  0, 1'b0, 3,    1'b1, 1,    3,    0, 1, 20, 64'd0};

        areset = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1; stall_pct = 0;
        i_guard_cycles = '0; i_nfft = '0; i_cp_len = '0; i_cp_en = 1'b0;
        i_pre_len = '0; i_fill_mode = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", longint'(m_axis_tvalid), 0);
        check("rst_tdata", longint'(m_axis_tdata), 0);
        check("rst_tlast", longint'(m_axis_tlast), 0);
        check("rst_s_tready", longint'(s_axis_tready), 0);
        check("rst_busy_state", longint'({o_busy, o_state}), 0);
        check("rst_stats", longint'({o_sym_count, o_err_short}), 0);
        areset = 1'b0;
        @(posedge aclk); #1;
        check("idle_s_tready", longint'(s_axis_tready), 1);
        mon_en = 1'b1;

        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of a guard interval, then a clean frame.
        mon_en = 1'b0;
        stall_pct = 0;
        i_guard_cycles = 10; i_nfft = 7; i_cp_len = '0; i_cp_en = 1'b0;
        i_pre_len = 4; i_fill_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tlast  = 1'b0;
            @(posedge aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        for (int c = 0; c < 50 && o_state != 2'd2; c++) begin
            @(posedge aclk); #1;
        end
        check("c6_in_guard", longint'(o_state), 2);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b1;
        #1;
        check("c6_tvalid", longint'(m_axis_tvalid), 0);
        check("c6_tdata", longint'(m_axis_tdata), 0);
        check("c6_tlast", longint'(m_axis_tlast), 0);
        check("c6_s_tready", longint'(s_axis_tready), 0);
        check("c6_busy_state", longint'({o_busy, o_state}), 0);
        check("c6_stats", longint'({o_sym_count, o_err_short}), 0);
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_q.delete();
        @(posedge aclk); #1;
        mon_en = 1'b1;
        run_vec("c6_next", tbl[4]);

        // Random frames against the model.
        for (int r = 0; r < 12; r++) begin
            rv.guard     = int'($urandom_range(0, 4));
            rv.nfft      = int'($urandom_range(0, 15));
            rv.cp_len    = int'($urandom_range(0, 3));
            rv.cp_en     = 1'($urandom_range(0, 1));
            rv.pre_len   = int'($urandom_range(0, 20));
            rv.fill      = 1'($urandom_range(0, 1));
            rv.n         = int'($urandom_range(1, rv.pre_len + 1 + 3 * (rv.nfft + rv.cp_len + 2)));
            rv.exp_out   = -1;
            rv.exp_syms  = -1;
            rv.exp_err   = -1;
            rv.stall     = int'($urandom_range(0, 40));
            rv.last_word = 64'd0;
            run_vec($sformatf("rnd%0d", r), rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
